// File: rtl/snn_inference_controller.sv
// Sequences one spiking-network inference per image: latch pixels, hold the
// datapath in reset to settle, run for TIME_UNITS steps counting spikes, hand off result.
module snn_inference_controller #(
    parameter int N_PIX      = 25,
    parameter int TIME_UNITS = 15,
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             img_valid,
    output logic             img_ready,
    input  logic [N_PIX-1:0] img_pixels,
    output logic             snn_reset,
    output logic [N_PIX-1:0] snn_pixels,
    input  logic [1:0]       snn_spike,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_label,
    output logic [CNT_W-1:0] res_count0,
    output logic [CNT_W-1:0] res_count1,
    output logic             busy,
    output logic [15:0]      img_count
);

    localparam int TMR_MAX = (TIME_UNITS > SETTLE_CYC) ? TIME_UNITS : SETTLE_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [CNT_W-1:0]   cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic [CNT_W-1:0]   res_c0_q, res_c0_d, res_c1_q, res_c1_d;
    logic [N_PIX-1:0]   pix_q, pix_d;
    logic [15:0]        img_cnt_q, img_cnt_d;
    logic               img_ready_q, img_ready_d;
    logic               snn_reset_q, snn_reset_d;
    logic               res_valid_q, res_valid_d;
    logic               res_label_q, res_label_d;
    logic               busy_q, busy_d;
    logic               accept, handoff, last_settle, last_run;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic s);
        if (s && (c != {CNT_W{1'b1}})) return c + CNT_W'(1);
        return c;
    endfunction

    assign accept      = (state_q == S_IDLE) && img_valid && img_ready_q;
    assign handoff     = (state_q == S_DONE) && res_valid_q && res_ready;
    assign last_settle = (tmr_q == TMR_W'(SETTLE_CYC - 1));
    assign last_run    = (tmr_q == TMR_W'(TIME_UNITS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tmr_q       <= '0;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
            res_c0_q    <= '0;
            res_c1_q    <= '0;
            pix_q       <= '0;
            img_cnt_q   <= '0;
            img_ready_q <= 1'b0;
            snn_reset_q <= 1'b1;
            res_valid_q <= 1'b0;
            res_label_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
            res_c0_q    <= res_c0_d;
            res_c1_q    <= res_c1_d;
            pix_q       <= pix_d;
            img_cnt_q   <= img_cnt_d;
            img_ready_q <= img_ready_d;
            snn_reset_q <= snn_reset_d;
            res_valid_q <= res_valid_d;
            res_label_q <= res_label_d;
            busy_q      <= busy_d;
        end
    end

    // One shared timer paces both the settle window and the run window.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        case (state_q)
            S_IDLE: if (accept) begin
                state_d = S_SETTLE;
                tmr_d   = '0;
            end
            S_SETTLE: if (last_settle) begin
                state_d = S_RUN;
                tmr_d   = '0;
            end else begin
                tmr_d = tmr_q + TMR_W'(1);
            end
            S_RUN: if (last_run) begin
                state_d = S_DONE;
                tmr_d   = '0;
            end else begin
                tmr_d = tmr_q + TMR_W'(1);
            end
            S_DONE: if (handoff) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        img_ready_d = (state_d == S_IDLE);
        snn_reset_d = (state_d != S_RUN);
        res_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
        pix_d       = accept ? img_pixels : pix_q;
        cnt0_d      = cnt0_q;
        cnt1_d      = cnt1_q;
        res_c0_d    = res_c0_q;
        res_c1_d    = res_c1_q;
        res_label_d = res_label_q;
        img_cnt_d   = handoff ? img_cnt_q + 16'd1 : img_cnt_q;
        if (accept) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end else if (state_q == S_RUN) begin
            cnt0_d = sat_inc(cnt0_q, snn_spike[0]);
            cnt1_d = sat_inc(cnt1_q, snn_spike[1]);
        end
        // The last run cycle's spike is folded in before the result is captured.
        if ((state_q == S_RUN) && last_run) begin
            res_c0_d    = cnt0_d;
            res_c1_d    = cnt1_d;
            res_label_d = (cnt0_d < cnt1_d);
        end
    end

    assign img_ready  = img_ready_q;
    assign snn_reset  = snn_reset_q;
    assign snn_pixels = pix_q;
    assign res_valid  = res_valid_q;
    assign res_label  = res_label_q;
    assign res_count0 = res_c0_q;
    assign res_count1 = res_c1_q;
    assign busy       = busy_q;
    assign img_count  = img_cnt_q;

endmodule

// File: tb/tb_snn_inference_controller.sv
// Directed bench for snn_inference_controller: a default instance plus a
// CNT_W=3 instance sharing the same stimulus to exercise counter saturation.
module tb_snn_inference_controller;

    logic        clk = 1'b0;
    logic        reset, img_valid, res_ready;
    logic [24:0] img_pixels;
    logic [1:0]  snn_spike;

    logic        img_ready, snn_reset, res_valid, res_label, busy;
    logic [24:0] snn_pixels;
    logic [7:0]  res_count0, res_count1;
    logic [15:0] img_count;

    logic        b_img_ready, b_snn_reset, b_res_valid, b_res_label, b_busy;
    logic [24:0] b_snn_pixels;
    logic [2:0]  b_res_count0, b_res_count1;
    logic [15:0] b_img_count;

    int n_cmp = 0;
    int n_fail = 0;
    int n_img = 0;

    typedef struct {
        logic [24:0] pix;
        logic [14:0] m0;
        logic [14:0] m1;
        logic        inj;
        logic [7:0]  c0;
        logic [7:0]  c1;
        logic        lbl;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    snn_inference_controller dut_a (
        .clk(clk), .reset(reset), .img_valid(img_valid), .img_ready(img_ready),
        .img_pixels(img_pixels), .snn_reset(snn_reset), .snn_pixels(snn_pixels),
        .snn_spike(snn_spike), .res_valid(res_valid), .res_ready(res_ready),
        .res_label(res_label), .res_count0(res_count0), .res_count1(res_count1),
        .busy(busy), .img_count(img_count)
    );

    snn_inference_controller #(.CNT_W(3)) dut_b (
        .clk(clk), .reset(reset), .img_valid(img_valid), .img_ready(b_img_ready),
        .img_pixels(img_pixels), .snn_reset(b_snn_reset), .snn_pixels(b_snn_pixels),
        .snn_spike(snn_spike), .res_valid(b_res_valid), .res_ready(res_ready),
        .res_label(b_res_label), .res_count0(b_res_count0), .res_count1(b_res_count1),
        .busy(b_busy), .img_count(b_img_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Enters in an IDLE cycle T, returns at cycle T+18 (first DONE cycle).
    task automatic run_to_done(input logic [24:0] pix, input logic [14:0] m0,
                               input logic [14:0] m1, input logic inj);
        chk("img_ready_idle", 32'(img_ready), 32'd1);
        img_valid  = 1'b1;
        img_pixels = pix;
        snn_spike  = inj ? 2'b11 : 2'b00;
        tick();
        img_valid = 1'b0;
        chk("img_ready_drop", 32'(img_ready), 32'd0);
        chk("snn_pixels", 32'(snn_pixels), 32'(pix));
        for (int k = 1; k <= 17; k++) begin
            if (k >= 3) snn_spike = {m1[k-3], m0[k-3]};
            else        snn_spike = inj ? 2'b11 : 2'b00;
            chk("snn_reset_seq", 32'(snn_reset), 32'(k <= 2));
            chk("busy_seq", 32'(busy), 32'd1);
            chk("res_valid_early", 32'(res_valid), 32'd0);
            tick();
        end
        snn_spike = inj ? 2'b11 : 2'b00;
        chk("res_valid_rise", 32'(res_valid), 32'd1);
        chk("snn_reset_done", 32'(snn_reset), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int t[3];
        int hs;
        logic seen;

        vecs[0] = '{25'h01F_0000, 15'h000F, 15'h7FC0, 1'b0, 8'd4,  8'd9, 1'b1};
        vecs[1] = '{25'h155_5555, 15'h5111, 15'h5111, 1'b1, 8'd5,  8'd5, 1'b0};
        vecs[2] = '{25'h1AA_AAAA, 15'h7FFF, 15'h0001, 1'b0, 8'd15, 8'd1, 1'b0};
        vecs[3] = '{25'h1FF_FFFF, 15'h0000, 15'h0000, 1'b1, 8'd0,  8'd0, 1'b0};
        vecs[4] = '{25'h000_0001, 15'h0000, 15'h4000, 1'b0, 8'd0,  8'd1, 1'b1};
        vecs[5] = '{25'h100_0000, 15'h0001, 15'h0000, 1'b0, 8'd1,  8'd0, 1'b0};

        reset = 1'b1; img_valid = 1'b0; res_ready = 1'b0;
        img_pixels = '0; snn_spike = 2'b00;

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_img_ready", 32'(img_ready), 32'd0);
            chk("rst_snn_reset", 32'(snn_reset), 32'd1);
            chk("rst_res_valid", 32'(res_valid), 32'd0);
        end
        reset = 1'b0;
        tick();
        chk("rel_img_ready", 32'(img_ready), 32'd1);
        chk("rel_snn_reset", 32'(snn_reset), 32'd1);
        chk("rel_res_valid", 32'(res_valid), 32'd0);
        chk("rel_busy", 32'(busy), 32'd0);
        chk("rel_img_count", 32'(img_count), 32'd0);
        chk("rel_snn_pixels", 32'(snn_pixels), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_to_done(vecs[i].pix, vecs[i].m0, vecs[i].m1, vecs[i].inj);
            chk("vec_count0", 32'(res_count0), 32'(vecs[i].c0));
            chk("vec_count1", 32'(res_count1), 32'(vecs[i].c1));
            chk("vec_label", 32'(res_label), 32'(vecs[i].lbl));
            chk("vec_b_count0", 32'(b_res_count0),
                (vecs[i].c0 > 8'd7) ? 32'd7 : 32'(vecs[i].c0));
            chk("vec_b_count1", 32'(b_res_count1),
                (vecs[i].c1 > 8'd7) ? 32'd7 : 32'(vecs[i].c1));
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            snn_spike = 2'b00;
            n_img++;
            chk("vec_res_valid_drop", 32'(res_valid), 32'd0);
            chk("vec_img_ready_back", 32'(img_ready), 32'd1);
            chk("vec_img_count", 32'(img_count), 32'(n_img));
            chk("vec_count0_held", 32'(res_count0), 32'(vecs[i].c0));
            chk("vec_label_held", 32'(res_label), 32'(vecs[i].lbl));
        end

        // Backpressure with saturation; an image offered during the stall must be ignored.
        run_to_done(25'h0AB_CDEF, 15'h7FFF, 15'h7FFF, 1'b0);
        img_valid  = 1'b1;
        img_pixels = 25'h012_3456;
        for (int i = 0; i < 10; i++) begin
            snn_spike = 2'b11;
            chk("bp_res_valid", 32'(res_valid), 32'd1);
            chk("bp_img_ready", 32'(img_ready), 32'd0);
            chk("bp_count0", 32'(res_count0), 32'd15);
            chk("bp_count1", 32'(res_count1), 32'd15);
            chk("bp_label", 32'(res_label), 32'd0);
            chk("sat_b_count0", 32'(b_res_count0), 32'd7);
            chk("sat_b_count1", 32'(b_res_count1), 32'd7);
            chk("bp_pixels", 32'(snn_pixels), 32'h0AB_CDEF);
            tick();
        end
        img_valid = 1'b0;
        snn_spike = 2'b00;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_img++;
        chk("bp_release_valid", 32'(res_valid), 32'd0);
        chk("bp_release_ready", 32'(img_ready), 32'd1);
        chk("bp_img_count", 32'(img_count), 32'(n_img));

        // Back-to-back throughput with both handshakes tied high.
        img_valid  = 1'b1;
        res_ready  = 1'b1;
        img_pixels = 25'h0F0_F0F0;
        hs = 0;
        for (int c = 0; c < 100 && hs < 3; c++) begin
            if (img_ready) begin
                t[hs] = c;
                hs++;
            end
            tick();
        end
        img_valid = 1'b0;
        chk("b2b_handshakes", 32'(hs), 32'd3);
        chk("b2b_gap01", t[1] - t[0], 32'd19);
        chk("b2b_gap12", t[2] - t[1], 32'd19);
        for (int i = 0; i < 18; i++) tick();
        n_img += 3;
        chk("b2b_img_count", 32'(img_count), 32'(n_img));
        chk("b2b_idle_ready", 32'(img_ready), 32'd1);
        res_ready = 1'b0;

        // Reset asserted during the 7th run cycle (T+9).
        img_valid  = 1'b1;
        img_pixels = 25'h155_5555;
        tick();
        img_valid = 1'b0;
        snn_spike = 2'b11;
        for (int i = 0; i < 8; i++) tick();
        chk("mid_run_active", 32'(snn_reset), 32'd0);
        reset = 1'b1;
        tick();
        chk("mr_snn_reset", 32'(snn_reset), 32'd1);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_img_ready", 32'(img_ready), 32'd0);
        chk("mr_res_valid", 32'(res_valid), 32'd0);
        chk("mr_count0", 32'(res_count0), 32'd0);
        chk("mr_count1", 32'(res_count1), 32'd0);
        chk("mr_img_count", 32'(img_count), 32'd0);
        chk("mr_pixels", 32'(snn_pixels), 32'd0);
        reset = 1'b0;
        res_ready = 1'b1;
        tick();
        chk("mr_ready_back", 32'(img_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (res_valid) seen = 1'b1;
            tick();
        end
        snn_spike = 2'b00;
        chk("mr_no_result", 32'(seen), 32'd0);
        chk("mr_img_count_after", 32'(img_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
